// File: rtl/amp_i2c_arbiter_if.sv
// rtl/amp_i2c_arbiter_if.sv - requester and I2C-master signal bundle for the amplifier I2C arbiter
interface amp_i2c_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req_in;
  logic [NREQ-1:0]   rnw_in;
  logic [8*NREQ-1:0] reg_in;
  logic [8*NREQ-1:0] wdata_in;
  logic [NREQ-1:0]   grant_out;
  logic [NREQ-1:0]   done_out;
  logic              err_out;
  logic [7:0]        rdata_out;
  logic              m_start;
  logic              m_rnw;
  logic [7:0]        m_reg;
  logic [7:0]        m_wdata;
  logic              m_busy;
  logic              m_done;
  logic              m_nack;
  logic [7:0]        m_rdata;
  logic              m_abort;

  // slave: the arbiter itself; master: requesters plus the I2C master around it
  modport slave (
    input  req_in, rnw_in, reg_in, wdata_in, m_busy, m_done, m_nack, m_rdata,
    output grant_out, done_out, err_out, rdata_out, m_start, m_rnw, m_reg, m_wdata, m_abort
  );
  modport master (
    output req_in, rnw_in, reg_in, wdata_in, m_busy, m_done, m_nack, m_rdata,
    input  grant_out, done_out, err_out, rdata_out, m_start, m_rnw, m_reg, m_wdata, m_abort
  );
endinterface

// File: rtl/amp_i2c_arbiter.sv
// rtl/amp_i2c_arbiter.sv - shares one amplifier I2C master between NREQ register-access requesters
module amp_i2c_arbiter #(
  parameter int NREQ    = 3,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic              clk_in,
  input  logic              resetb,
  amp_i2c_arbiter_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   winner_q, winner_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic            err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            start_q, start_d;
  logic            abort_q, abort_d;
  logic            rnw_q, rnw_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      wdata_q, wdata_d;

  logic [IW-1:0]   sel_idx;
  logic            sel_found;
  logic [IW:0]     cand;

  // Requester 0 always wins; the others are scanned from rr_q, wrapping within 1..NREQ-1.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    if (bus.req_in[0]) begin
      sel_found = 1'b1;
    end else begin
      for (int off = 0; off < NREQ - 1; off++) begin
        cand = {1'b0, rr_q} + (IW+1)'(off);
        if (cand >= (IW+1)'(NREQ)) begin
          cand = cand - (IW+1)'(NREQ - 1);
        end
        if (!sel_found && bus.req_in[cand[IW-1:0]]) begin
          sel_idx   = cand[IW-1:0];
          sel_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      state_q  <= S_IDLE;
      winner_q <= '0;
      rr_q     <= IW'(1);
      grant_q  <= '0;
      done_q   <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      rnw_q    <= 1'b0;
      reg_q    <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      rnw_q    <= rnw_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    done_d   = '0;
    timer_d  = timer_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    rnw_d    = rnw_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          winner_d = sel_idx;
          grant_d  = ONE_HOT0 << sel_idx;
          state_d  = S_GRANT;
        end
      end
      S_GRANT: begin
        rnw_d   = bus.rnw_in[winner_q];
        reg_d   = bus.reg_in[{winner_q, 3'b000} +: 8];
        wdata_d = bus.wdata_in[{winner_q, 3'b000} +: 8];
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!bus.m_busy) begin
          start_d = 1'b1;
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TO_W'(1);
        // A completion arriving on the timeout cycle takes precedence over the abort.
        if (bus.m_done) begin
          err_d = bus.m_nack;
          if (rnw_q) begin
            rdata_d = bus.m_rdata;
          end
          state_d = S_DONE;
        end else if (timer_q == TO_W'(TIMEOUT - 1)) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = grant_q;
        grant_d = '0;
        if (winner_q != '0) begin
          rr_d = (winner_q == IW'(NREQ - 1)) ? IW'(1) : winner_q + IW'(1);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.grant_out = grant_q;
  assign bus.done_out  = done_q;
  assign bus.err_out   = err_q;
  assign bus.rdata_out = rdata_q;
  assign bus.m_start   = start_q;
  assign bus.m_abort   = abort_q;
  assign bus.m_rnw     = rnw_q;
  assign bus.m_reg     = reg_q;
  assign bus.m_wdata   = wdata_q;

endmodule

// File: tb/tb_amp_i2c_arbiter.sv
// tb/tb_amp_i2c_arbiter.sv - scoreboard bench for amp_i2c_arbiter with a scripted I2C master model
module tb_amp_i2c_arbiter;
  localparam int NREQ = 3;
  localparam int TOUT = 20;

  logic clk_in = 1'b0;
  logic resetb;
  always #5 clk_in = ~clk_in;

  amp_i2c_arbiter_if #(.NREQ(NREQ)) bus();

  amp_i2c_arbiter #(.NREQ(NREQ), .TO_W(16), .TIMEOUT(TOUT)) dut (
    .clk_in (clk_in),
    .resetb (resetb),
    .bus    (bus)
  );

  typedef struct { logic [2:0] grant; logic rnw; logic [7:0] rg; logic [7:0] wd; } cmd_t;
  typedef struct { logic [2:0] done; logic err; logic [7:0] rdata; } dn_t;

  cmd_t cmd_q[$];
  dn_t  dn_q[$];
  int   abort_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int start_cnt = 0;

  logic       mute       = 1'b0;
  int         resp_delay = 0;
  logic       nack_cfg   = 1'b0;
  logic [7:0] rdata_cfg  = 8'h5A;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic rnw, input logic [7:0] rg, input logic [7:0] wd);
    bus.rnw_in[idx]          = rnw;
    bus.reg_in[idx*8 +: 8]   = rg;
    bus.wdata_in[idx*8 +: 8] = wd;
    bus.req_in[idx]          = 1'b1;
  endtask

  task automatic exp_cmd(input int idx, input logic rnw, input logic [7:0] rg, input logic [7:0] wd);
    cmd_t c;
    c.grant = 3'(1 << idx);
    c.rnw   = rnw;
    c.rg    = rg;
    c.wd    = wd;
    cmd_q.push_back(c);
  endtask

  task automatic exp_txn(input int idx, input logic rnw, input logic [7:0] rg, input logic [7:0] wd,
                         input logic err, input logic [7:0] rd);
    dn_t d;
    exp_cmd(idx, rnw, rg, wd);
    d.done  = 3'(1 << idx);
    d.err   = err;
    d.rdata = rd;
    dn_q.push_back(d);
  endtask

  task automatic wait_dones(input int n, input string tag);
    int got;
    got = 0;
    for (int t = 0; t < 400 && got < n; t++) begin
      @(negedge clk_in);
      if (bus.done_out != 0) got++;
    end
    chk({tag, "_done_count"}, 32'(got), 32'(n));
  endtask

  always @(posedge clk_in) cyc++;

  // Monitor: pops expectations whenever the DUT presents m_start, m_abort or done_out.
  always @(negedge clk_in) begin
    cmd_t ce;
    dn_t  de;
    int   ae;
    if (resetb) begin
      if (bus.m_start) begin
        start_cnt++;
        start_cyc = cyc;
        if (cmd_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_m_start: got m_reg 0x%0h, expected no command", bus.m_reg);
        end else begin
          ce = cmd_q.pop_front();
          chk("cmd_grant", 32'(bus.grant_out), 32'(ce.grant));
          chk("cmd_rnw",   32'(bus.m_rnw),     32'(ce.rnw));
          chk("cmd_reg",   32'(bus.m_reg),     32'(ce.rg));
          chk("cmd_wdata", 32'(bus.m_wdata),   32'(ce.wd));
        end
      end
      if (bus.m_abort) begin
        if (abort_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_m_abort: got abort at cycle %0d, expected none", cyc);
        end else begin
          ae = abort_q.pop_front();
          chk("abort_delay", 32'(cyc - start_cyc), 32'(ae));
        end
      end
      if (bus.done_out != 0) begin
        if (dn_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got done_out 0x%0h, expected none", bus.done_out);
        end else begin
          de = dn_q.pop_front();
          chk("done_onehot", 32'(bus.done_out),  32'(de.done));
          chk("done_err",    32'(bus.err_out),   32'(de.err));
          chk("done_rdata",  32'(bus.rdata_out), 32'(de.rdata));
          chk("done_grant_clear", 32'(bus.grant_out), 32'(0));
        end
      end
    end
  end

  // I2C master model: answers each m_start resp_delay cycles later unless muted.
  initial begin
    bus.m_done  = 1'b0;
    bus.m_nack  = 1'b0;
    bus.m_rdata = 8'h00;
    forever begin
      @(negedge clk_in);
      if (resetb && bus.m_start && !mute) begin
        for (int k = 0; k < resp_delay; k++) @(negedge clk_in);
        bus.m_nack  = nack_cfg;
        bus.m_rdata = rdata_cfg;
        bus.m_done  = 1'b1;
        @(negedge clk_in);
        bus.m_done  = 1'b0;
        bus.m_nack  = 1'b0;
        bus.m_rdata = 8'h00;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    resetb       = 1'b0;
    bus.req_in   = '0;
    bus.rnw_in   = '0;
    bus.reg_in   = '0;
    bus.wdata_in = '0;
    bus.m_busy   = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_grant", 32'(bus.grant_out), 32'(0));
    chk("rst_done",  32'(bus.done_out),  32'(0));
    chk("rst_flags", 32'({bus.err_out, bus.m_start, bus.m_abort, bus.m_rnw}), 32'(0));
    chk("rst_rdata", 32'(bus.rdata_out), 32'(0));
    chk("rst_mreg",  32'(bus.m_reg),     32'(0));
    chk("rst_mwdata", 32'(bus.m_wdata),  32'(0));
    resetb = 1'b1;
    @(negedge clk_in);

    // T2: all requesting; req0 dominates, then 1 and 2 alternate
    exp_txn(0, 1'b0, 8'h00, 8'h10, 1'b0, 8'h00);
    exp_txn(0, 1'b0, 8'h00, 8'h10, 1'b0, 8'h00);
    exp_txn(1, 1'b0, 8'h01, 8'h11, 1'b0, 8'h00);
    exp_txn(2, 1'b0, 8'h02, 8'h12, 1'b0, 8'h00);
    exp_txn(1, 1'b0, 8'h01, 8'h11, 1'b0, 8'h00);
    exp_txn(2, 1'b0, 8'h02, 8'h12, 1'b0, 8'h00);
    set_req(0, 1'b0, 8'h00, 8'h10);
    set_req(1, 1'b0, 8'h01, 8'h11);
    set_req(2, 1'b0, 8'h02, 8'h12);
    wait_dones(2, "t2_req0");
    bus.req_in[0] = 1'b0;
    wait_dones(4, "t2_rr");
    bus.req_in = '0;

    // T1: single write with cycle-accurate latency
    @(negedge clk_in);
    exp_txn(1, 1'b0, 8'h1D, 8'h80, 1'b0, 8'h00);
    set_req(1, 1'b0, 8'h1D, 8'h80);
    @(posedge clk_in); #1 chk("t1_grant_edge1", 32'(bus.grant_out), 32'(3'b010));
    @(posedge clk_in); #1 chk("t1_no_start_edge2", 32'(bus.m_start), 32'(0));
    @(posedge clk_in); #1 chk("t1_start_edge3", 32'(bus.m_start), 32'(1));
    @(posedge clk_in); #1 chk("t1_no_done_edge4", 32'(bus.done_out), 32'(0));
    @(posedge clk_in); #1 chk("t1_done_edge5", 32'(bus.done_out), 32'(3'b010));
    bus.req_in = '0;

    // T3: read captures rdata, a following write leaves it untouched
    @(negedge clk_in);
    rdata_cfg = 8'hA5;
    exp_txn(2, 1'b1, 8'h7C, 8'h00, 1'b0, 8'hA5);
    set_req(2, 1'b1, 8'h7C, 8'h00);
    wait_dones(1, "t3_read");
    bus.req_in = '0;
    rdata_cfg = 8'h5A;
    exp_txn(1, 1'b0, 8'h10, 8'h33, 1'b0, 8'hA5);
    set_req(1, 1'b0, 8'h10, 8'h33);
    wait_dones(1, "t3_write");
    bus.req_in = '0;

    // T4: master never completes
    mute = 1'b1;
    exp_txn(1, 1'b0, 8'h20, 8'h01, 1'b1, 8'hA5);
    abort_q.push_back(TOUT);
    set_req(1, 1'b0, 8'h20, 8'h01);
    wait_dones(1, "t4_timeout");
    bus.req_in = '0;
    mute = 1'b0;

    // T5: busy master holds off m_start; the timer must not run meanwhile
    bus.m_busy = 1'b1;
    resp_delay = 18;
    n0 = start_cnt;
    exp_txn(2, 1'b0, 8'h30, 8'h02, 1'b0, 8'hA5);
    set_req(2, 1'b0, 8'h30, 8'h02);
    repeat (12) @(negedge clk_in);
    chk("t5_no_start_while_busy", 32'(start_cnt), 32'(n0));
    bus.m_busy = 1'b0;
    wait_dones(1, "t5_busy");
    bus.req_in = '0;

    // NACK reported as error
    resp_delay = 2;
    nack_cfg   = 1'b1;
    exp_txn(1, 1'b0, 8'h40, 8'h04, 1'b1, 8'hA5);
    set_req(1, 1'b0, 8'h40, 8'h04);
    wait_dones(1, "nack");
    bus.req_in = '0;
    nack_cfg = 1'b0;

    // m_done on the timeout cycle wins: no abort, err from nack
    resp_delay = TOUT - 1;
    rdata_cfg  = 8'hC3;
    exp_txn(2, 1'b1, 8'h50, 8'h00, 1'b0, 8'hC3);
    set_req(2, 1'b1, 8'h50, 8'h00);
    wait_dones(1, "coincident");
    bus.req_in = '0;
    resp_delay = 0;
    rdata_cfg  = 8'h5A;

    // T6: reset while waiting on the master
    mute = 1'b1;
    n0 = start_cnt;
    exp_cmd(1, 1'b0, 8'h60, 8'h06);
    set_req(1, 1'b0, 8'h60, 8'h06);
    for (int t = 0; t < 20 && start_cnt == n0; t++) @(negedge clk_in);
    chk("t6_started", 32'(start_cnt), 32'(n0 + 1));
    repeat (3) @(negedge clk_in);
    resetb = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(bus.grant_out), 32'(0));
    chk("t6_rst_mreg",  32'(bus.m_reg),     32'(0));
    chk("t6_rst_mwdata", 32'(bus.m_wdata),  32'(0));
    chk("t6_rst_rdata", 32'(bus.rdata_out), 32'(0));
    chk("t6_rst_flags", 32'({bus.done_out, bus.err_out, bus.m_start, bus.m_abort}), 32'(0));
    bus.req_in = '0;
    mute = 1'b0;
    @(negedge clk_in);
    chk("t6_no_abort_in_reset", 32'(bus.m_abort), 32'(0));
    resetb = 1'b1;
    @(negedge clk_in);
    exp_txn(2, 1'b0, 8'h70, 8'h07, 1'b0, 8'h00);
    set_req(2, 1'b0, 8'h70, 8'h07);
    @(posedge clk_in); #1 chk("t6_grant_after_reset", 32'(bus.grant_out), 32'(3'b100));
    wait_dones(1, "t6_after_reset");
    bus.req_in = '0;

    repeat (5) @(negedge clk_in);
    chk("queues_drained", 32'(cmd_q.size() + dn_q.size() + abort_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
